// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter sharing one slave read port; one transaction in flight.
// Define ARB_RR_EN for round-robin tie breaking; otherwise the LSU (master 1) wins ties.
module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_ar_valid_i,
  output logic              m0_ar_ready_o,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_r_valid_o,
  input  logic              m0_r_ready_i,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic [1:0]        m0_r_resp_o,
  input  logic              m1_ar_valid_i,
  output logic              m1_ar_ready_o,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_r_valid_o,
  input  logic              m1_r_ready_i,
  output logic [DATA_W-1:0] m1_r_data_o,
  output logic [1:0]        m1_r_resp_o,
  output logic              s_ar_valid_o,
  input  logic              s_ar_ready_i,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_r_valid_i,
  output logic              s_r_ready_o,
  input  logic [DATA_W-1:0] s_r_data_i,
  input  logic [1:0]        s_r_resp_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              win1;
`ifdef ARB_RR_EN
  logic              last_q, last_d;
`endif

  always_comb begin
`ifdef ARB_RR_EN
    if (m0_ar_valid_i && m1_ar_valid_i) win1 = ~last_q;
    else                                win1 = m1_ar_valid_i;
`else
    win1 = m1_ar_valid_i;
`endif
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
`ifdef ARB_RR_EN
    last_d        = last_q;
`endif
    m0_ar_ready_o = 1'b0;
    m1_ar_ready_o = 1'b0;
    m0_r_valid_o  = 1'b0;
    m1_r_valid_o  = 1'b0;
    s_r_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so a request held across reset is not acknowledged.
        if ((m0_ar_valid_i || m1_ar_valid_i) && !rst_n) begin
          m0_ar_ready_o = ~win1;
          m1_ar_ready_o = win1;
          addr_d        = win1 ? m1_ar_addr_i : m0_ar_addr_i;
          grant_d       = win1 ? 2'b10 : 2'b01;
`ifdef ARB_RR_EN
          last_d        = win1;
`endif
          state_d       = ADDR;
        end
      end
      ADDR: begin
        if (s_ar_ready_i) state_d = DATA;
      end
      DATA: begin
        m0_r_valid_o = grant_q[0] & s_r_valid_i;
        m1_r_valid_o = grant_q[1] & s_r_valid_i;
        s_r_ready_o  = (grant_q[0] & m0_r_ready_i) | (grant_q[1] & m1_r_ready_i);
        if (s_r_valid_i && s_r_ready_o) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      addr_q  <= '0;
`ifdef ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign s_ar_valid_o = (state_q == ADDR);
  assign s_ar_addr_o  = addr_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != IDLE);
  assign m0_r_data_o  = s_r_data_i;
  assign m0_r_resp_o  = s_r_resp_i;
  assign m1_r_data_o  = s_r_data_i;
  assign m1_r_resp_o  = s_r_resp_i;

endmodule

// File: doc/ysyx_22050019_axi_rd_arbiter.md
Name: ysyx_22050019_axi_rd_arbiter

Overview:
- Two-master, one-slave AXI-lite read-channel arbiter.
- Shares the icache/memory read port between the instruction fetch buffer (master 0) and the LSU (master 1).
- Handles single-beat 128-bit reads, with exactly one transaction outstanding at a time.
- Sits between the IFU/LSU and the cache/AXI bridge. A grant is held from AR acceptance until the R handshake completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 128, read data width (one cache line).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-high reset (asserted = 1)
- m0_ar_valid_i  in  1  fetch buffer read request
- m0_ar_ready_o  out  1  request accepted
- m0_ar_addr_i  in  ADDR_W  request address
- m0_r_valid_o  out  1  read data valid to master 0
- m0_r_ready_i  in  1  master 0 ready for data
- m0_r_data_o  out  DATA_W  read data
- m0_r_resp_o  out  2  read response
- m1_ar_valid_i, m1_ar_ready_o, m1_ar_addr_i, m1_r_valid_o, m1_r_ready_i, m1_r_data_o, m1_r_resp_o: same as master 0, for the LSU
- s_ar_valid_o  out  1  request to slave
- s_ar_ready_i  in  1  slave accepts address
- s_ar_addr_o  out  ADDR_W  latched address
- s_r_valid_i  in  1  slave data valid
- s_r_ready_o  out  1  ready to slave
- s_r_data_i  in  DATA_W  slave data
- s_r_resp_i  in  2  slave response
- grant_o  out  2  one-hot owner; 00 when idle
- busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n=1):
  - State = IDLE; grant=00; s_ar_valid_o=0; s_ar_addr_o=0.
  - Round-robin pointer last=1, so master 0 wins the first tie.
  - All m*_ar_ready_o, m*_r_valid_o and s_r_ready_o are 0.
  - Reset mid-transaction abandons the transaction; the slave side is reset by the same signal.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - The winner is chosen combinationally among asserted m*_ar_valid_i.
  - The winner's m*_ar_ready_o = 1 in the same cycle; the loser's is 0.
  - On that handshake: latch the address into s_ar_addr_o, set grant, set last=winner, go to ADDR.
  - With no request, stay in IDLE with all ready outputs 0.
- ADDR:
  - s_ar_valid_o = 1, registered; it first rises the cycle after the master handshake.
  - s_ar_addr_o is stable while s_ar_valid_o = 1.
  - On s_ar_ready_i = 1, go to DATA; s_ar_valid_o deasserts the next cycle.
  - All m*_ar_ready_o = 0.
- DATA:
  - Combinational routing: granted m_r_valid_o = s_r_valid_i; s_r_ready_o = granted m_r_ready_i.
  - Granted m_r_data_o/m_r_resp_o = slave values.
  - The non-granted master sees r_valid = 0; its data outputs are don't-care, driven with slave data.
  - On s_r_valid_i & s_r_ready_o, return to IDLE; grant clears the next cycle.
  - A new request is acceptable no earlier than the cycle after the R handshake.
- Latency: master AR handshake at cycle N → s_ar_valid_o at N+1. R data reaches the master with zero added cycles.
- A requester dropping ar_valid before it is granted is legal; nothing is latched.
- A requester's ar_valid during another master's transaction is held off (ready = 0) with no loss.
- s_r_valid_i outside DATA is ignored; s_r_ready_o = 0 there.
- Resp pass-through is unmodified; SLVERR/DECERR still complete the transaction.
- Address is passed through unaligned and unmodified; alignment is the master's responsibility.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. On a tie, the master other than last wins; the pointer updates on each AR handshake.
- Undefined: fixed priority, LSU (master 1) always wins ties. The pointer register is not instantiated; reset behaviour is otherwise identical.

Test Plan:
- Single m0 read of 0x80000010, slave ready after 2 cycles, r_data=0x…DEADBEEF, resp 00.
  - m0_ar_ready_o pulses at cycle 0; s_ar_valid_o high cycles 1-3 with addr 0x80000010.
  - m0_r_valid_o mirrors s_r_valid_i; grant_o = 01 until the R handshake, then 00.
- Simultaneous m0 (0x80000000) and m1 (0x80001000) requests held asserted.
  - With ARB_RR_EN: m0 is served first, then m1.
  - Without ARB_RR_EN: m1 is served first, then m0.
  - m1_ar_ready_o stays 0 during m0's transaction.
- Back-to-back m1 requests while m0 is continuously requesting, with ARB_RR_EN.
  - Grants alternate m0, m1, m0.
  - There is exactly one idle cycle between the R handshake and the next ar_ready.
- Granted master holds r_ready=0 for 3 cycles while s_r_valid_i=1.
  - s_r_ready_o = 0 for those cycles; data is delivered on the first r_ready=1 cycle.
  - The other master's r_valid stays 0 throughout.
- rst_n asserted in DATA state, with no clock edge required.
  - Outputs go to 0 and grant_o = 00 immediately.
  - After release, a pending m0 request is accepted on the first cycle.
- Slave returns resp=2'b10 for an m1 read.
  - m1_r_resp_o = 10 and the transaction completes normally.
  - The arbiter returns to IDLE.
